// File: rtl/aim_pkg.sv
// Shared definitions for the AIM matcher and its downstream result collector.
//
// Contents:
//   N_WORD, POS_W, ITE_W, IDX_W  sizing constants for one AIM run
//   pos_t, ite_t, idx_t, cnt_t   field typedefs
//   mask_t                       one bit per word entry
//   coll_state_t                 result collector FSM states
package aim_pkg;

  localparam int N_WORD = 32;
  localparam int POS_W  = 9;
  localparam int ITE_W  = 3;
  localparam int IDX_W  = $clog2(N_WORD);

  typedef logic [POS_W-1:0]  pos_t;
  typedef logic [ITE_W-1:0]  ite_t;
  typedef logic [IDX_W-1:0]  idx_t;
  // One extra bit so a run where every word matches can still be counted.
  typedef logic [IDX_W:0]    cnt_t;
  typedef logic [N_WORD-1:0] mask_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } coll_state_t;

endpackage

// File: rtl/aim_prienc.sv
// Lowest-set-bit priority encoder, purely combinational.
//
// Ports:
//   vec           N-bit input vector
//   idx           index of the lowest set bit (0 when vec is empty)
//   any           at least one bit of vec is set
//   one_hot_only  exactly one bit of vec is set
module aim_prienc #(
  parameter int N  = 32,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          one_hot_only
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves nothing only when a single bit was set.
  always_comb begin
    any          = |vec;
    one_hot_only = any && ((vec & (vec - N'(1))) == '0);
  end

endmodule

// File: rtl/aim_result_collector.sv
// Result collector sitting behind the AIM matcher. On an i_finish pulse it
// snapshots the per-word match flags, positions and iteration index, then
// streams out one ready/valid beat per matching word (lowest index first),
// followed by a single-cycle done pulse carrying the number of beats sent.
// Holding its own snapshot lets AIM start the next iteration immediately.
//
// Ports:
//   i_clk, i_rst_n   clock and synchronous active-low reset
//   i_finish         one-cycle pulse: i_valid/i_pos/i_ite are valid now
//   i_valid, i_pos   per-word match flag and position from AIM
//   i_ite            iteration index of the result
//   o_busy           a snapshot is held (draining or reporting done)
//   o_data_valid / i_data_ready   beat handshake
//   o_word_idx, o_pos, o_ite, o_last   beat payload; o_last marks final beat
//   o_done, o_match_cnt   one-cycle completion pulse and beat count
//   o_overrun        sticky: an i_finish was dropped because we were busy
module aim_result_collector
  import aim_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_finish,
  input  logic [N_WORD-1:0]          i_valid,
  input  logic [N_WORD-1:0][POS_W-1:0] i_pos,
  input  logic [ITE_W-1:0]           i_ite,
  output logic                       o_busy,
  output logic                       o_data_valid,
  input  logic                       i_data_ready,
  output logic [IDX_W-1:0]           o_word_idx,
  output logic [POS_W-1:0]           o_pos,
  output logic [ITE_W-1:0]           o_ite,
  output logic                       o_last,
  output logic                       o_done,
  output logic [IDX_W:0]             o_match_cnt,
  output logic                       o_overrun
);

  coll_state_t              state, state_next;
  mask_t                    rem_mask;
  logic [N_WORD-1:0][POS_W-1:0] pos_q;
  ite_t                     ite_q;
  cnt_t                     cnt;
  logic                     overrun;

  idx_t                     enc_idx;
  logic                     enc_any;
  logic                     enc_one;

  aim_prienc #(
    .N  (N_WORD),
    .IW (IDX_W)
  ) u_prienc (
    .vec          (rem_mask),
    .idx          (enc_idx),
    .any          (enc_any),
    .one_hot_only (enc_one)
  );

  wire beat_taken = (state == EMIT) && i_data_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      rem_mask <= '0;
      pos_q    <= '0;
      ite_q    <= '0;
      cnt      <= '0;
      overrun  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && i_finish) begin
        rem_mask <= i_valid;
        pos_q    <= i_pos;
        ite_q    <= i_ite;
        cnt      <= '0;
      end else if (beat_taken) begin
        // Dropping the lowest set bit is the same bit the encoder just picked.
        rem_mask <= rem_mask & (rem_mask - mask_t'(1));
        cnt      <= cnt + cnt_t'(1);
      end
      // DONE counts as busy, so a finish landing there is also dropped.
      if (state != IDLE && i_finish) begin
        overrun <= 1'b1;
      end
    end
  end

  // Outputs depend only on registered state, so ready never reaches valid
  // combinationally and the payload stays put while the consumer stalls.
  always_comb begin
    state_next   = state;
    o_data_valid = 1'b0;
    o_word_idx   = '0;
    o_pos        = '0;
    o_ite        = '0;
    o_last       = 1'b0;
    o_done       = 1'b0;
    o_match_cnt  = '0;
    case (state)
      IDLE: begin
        if (i_finish) begin
          state_next = (|i_valid) ? EMIT : DONE;
        end
      end
      EMIT: begin
        o_data_valid = 1'b1;
        o_word_idx   = enc_idx;
        o_pos        = pos_q[enc_idx];
        o_ite        = ite_q;
        o_last       = enc_one;
        if (!enc_any) begin
          state_next = DONE;
        end else if (i_data_ready && enc_one) begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_done      = 1'b1;
        o_match_cnt = cnt;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_busy    = (state != IDLE);
  assign o_overrun = overrun;

endmodule

// File: tb/tb_aim_result_collector.sv
// Directed testbench for aim_result_collector. Expected beats are queued
// when a snapshot is triggered and popped as the collector emits them.
module tb_aim_result_collector;

  import aim_pkg::*;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [POS_W-1:0] pos;
    logic [ITE_W-1:0] ite;
    logic             last;
  } beat_t;

  logic                          i_clk;
  logic                          i_rst_n;
  logic                          i_finish;
  logic [N_WORD-1:0]             i_valid;
  logic [N_WORD-1:0][POS_W-1:0]  i_pos;
  logic [ITE_W-1:0]              i_ite;
  logic                          o_busy;
  logic                          o_data_valid;
  logic                          i_data_ready;
  logic [IDX_W-1:0]              o_word_idx;
  logic [POS_W-1:0]              o_pos;
  logic [ITE_W-1:0]              o_ite;
  logic                          o_last;
  logic                          o_done;
  logic [IDX_W:0]                o_match_cnt;
  logic                          o_overrun;

  beat_t exp_q[$];
  int    exp_cnt;
  int    total;
  int    bad;

  logic [N_WORD-1:0]             stim_valid;
  logic [N_WORD-1:0][POS_W-1:0]  stim_pos;

  aim_result_collector dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_finish     (i_finish),
    .i_valid      (i_valid),
    .i_pos        (i_pos),
    .i_ite        (i_ite),
    .o_busy       (o_busy),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready),
    .o_word_idx   (o_word_idx),
    .o_pos        (o_pos),
    .o_ite        (o_ite),
    .o_last       (o_last),
    .o_done       (o_done),
    .o_match_cnt  (o_match_cnt),
    .o_overrun    (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse i_finish for one cycle and queue the beats the snapshot should produce.
  task automatic applyStimulus(input logic [N_WORD-1:0] valid,
                               input logic [N_WORD-1:0][POS_W-1:0] pos,
                               input logic [ITE_W-1:0] ite);
    int last_i;
    beat_t b;
    last_i  = -1;
    exp_cnt = 0;
    for (int i = 0; i < N_WORD; i++) if (valid[i]) last_i = i;
    for (int i = 0; i < N_WORD; i++) begin
      if (valid[i]) begin
        b.idx  = IDX_W'(i);
        b.pos  = pos[i];
        b.ite  = ite;
        b.last = (i == last_i);
        exp_q.push_back(b);
        exp_cnt++;
      end
    end
    i_finish = 1'b1;
    i_valid  = valid;
    i_pos    = pos;
    i_ite    = ite;
    @(negedge i_clk);
    i_finish = 1'b0;
  endtask

  // Consume beats until o_done. mode 0: ready always high; mode 1: ready
  // 0,0,1 per beat. inject_at >= 0 pulses a second i_finish at that cycle.
  task automatic drainAndCheck(input int mode, input int inject_at, input int budget);
    int  stall;
    bit  got_done;
    stall    = 0;
    got_done = 1'b0;
    for (int it = 0; it < budget && !got_done; it++) begin
      checkOutput("beat_or_done", o_data_valid | o_done, 1);
      checkOutput("busy", o_busy, 1);
      if (o_done) begin
        checkOutput("match_cnt", o_match_cnt, exp_cnt);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("valid_in_done", o_data_valid, 0);
        if (mode == 0) checkOutput("drain_cycles", it, exp_cnt);
        got_done     = 1'b1;
        i_data_ready = 1'b0;
      end else if (o_data_valid) begin
        checkOutput("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          checkOutput("word_idx", o_word_idx, exp_q[0].idx);
          checkOutput("pos", o_pos, exp_q[0].pos);
          checkOutput("ite", o_ite, exp_q[0].ite);
          checkOutput("last", o_last, exp_q[0].last);
        end
        if (mode == 0 || stall == 2) begin
          i_data_ready = 1'b1;
          stall = 0;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          i_data_ready = 1'b0;
          stall++;
        end
      end
      if (it == inject_at) begin
        i_finish = 1'b1;
        i_valid  = '1;
        i_ite    = 3'd2;
      end else begin
        i_finish = 1'b0;
      end
      @(negedge i_clk);
    end
    i_finish     = 1'b0;
    i_data_ready = 1'b0;
    checkOutput("drain_timeout", got_done, 1);
    checkOutput("idle_after_done_busy", o_busy, 0);
    checkOutput("idle_after_done_done", o_done, 0);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    exp_cnt      = 0;
    i_rst_n      = 1'b0;
    i_finish     = 1'b0;
    i_valid      = '0;
    i_pos        = '0;
    i_ite        = '0;
    i_data_ready = 1'b0;

    // 1: reset state, then an empty snapshot
    repeat (2) @(negedge i_clk);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_valid", o_data_valid, 0);
    checkOutput("rst_idx", o_word_idx, 0);
    checkOutput("rst_pos", o_pos, 0);
    checkOutput("rst_last", o_last, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_cnt", o_match_cnt, 0);
    checkOutput("rst_overrun", o_overrun, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    applyStimulus('0, '0, 3'd0);
    checkOutput("zero_done_next_cycle", o_done, 1);
    drainAndCheck(0, -1, 5);

    // 2: three matches, ready held high
    stim_valid = '0;
    stim_valid[3] = 1'b1; stim_valid[7] = 1'b1; stim_valid[20] = 1'b1;
    for (int i = 0; i < N_WORD; i++) stim_pos[i] = POS_W'(i + 100);
    applyStimulus(stim_valid, stim_pos, 3'd5);
    drainAndCheck(0, -1, 10);

    // 3: same matches with ready stalling two cycles per beat
    applyStimulus(stim_valid, stim_pos, 3'd5);
    i_valid = '0;
    i_pos   = '0;
    drainAndCheck(1, -1, 20);

    // 4: every word matches
    for (int i = 0; i < N_WORD; i++) stim_pos[i] = POS_W'(i);
    applyStimulus('1, stim_pos, 3'd1);
    drainAndCheck(0, -1, 40);

    // 5: second finish arrives four cycles into a drain
    stim_valid = 32'h0000_5A5A;
    for (int i = 0; i < N_WORD; i++) stim_pos[i] = POS_W'(3 * i + 7);
    applyStimulus(stim_valid, stim_pos, 3'd6);
    drainAndCheck(0, 4, 20);
    checkOutput("overrun_set", o_overrun, 1);
    repeat (3) begin
      @(negedge i_clk);
      checkOutput("no_second_drain", o_data_valid | o_busy, 0);
    end

    // 6: reset in the middle of a drain, then a clean run
    stim_valid = 32'h0000_03FF;
    applyStimulus(stim_valid, stim_pos, 3'd3);
    i_data_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    i_data_ready = 1'b0;
    i_rst_n      = 1'b0;
    @(negedge i_clk);
    checkOutput("midrst_valid", o_data_valid, 0);
    checkOutput("midrst_busy", o_busy, 0);
    checkOutput("midrst_idx", o_word_idx, 0);
    checkOutput("midrst_overrun", o_overrun, 0);
    i_rst_n = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(negedge i_clk);
      checkOutput("midrst_no_done", o_done | o_busy, 0);
    end
    stim_valid = 32'h8000_0006;
    applyStimulus(stim_valid, stim_pos, 3'd4);
    drainAndCheck(0, -1, 10);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
